// File: rtl/prepare_output_data_pkg.sv
// Shared constants and types for the PL-to-PS event return path.
// Header field positions match the PS-to-PL injection path word layout.
package prepare_output_data_pkg;

    localparam logic [11:0] ADDR_STATUS = 12'h000;
    localparam logic [11:0] ADDR_HEADER = 12'h004;
    localparam logic [11:0] ADDR_TS     = 12'h008;
    localparam logic [11:0] ADDR_DROPS  = 12'h00C;

    localparam int unsigned STATUS_UNDERFLOW_BIT = 31;
    localparam int unsigned STATUS_EMPTY_BIT     = 30;
    localparam int unsigned STATUS_FULL_BIT      = 29;

    localparam int unsigned HDR_X_MSB     = 17;
    localparam int unsigned HDR_X_LSB     = 10;
    localparam int unsigned HDR_Y_MSB     = 9;
    localparam int unsigned HDR_Y_LSB     = 2;
    localparam int unsigned HDR_POL_BIT   = 1;
    localparam int unsigned HDR_VALID_BIT = 0;

    typedef enum logic [1:0] {
        RegStatus = 2'd0,
        RegHeader = 2'd1,
        RegTs     = 2'd2,
        RegDrops  = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [31:0] ts;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        pol;
    } event_t;

    function automatic logic [31:0] pack_header(input event_t ev);
        logic [31:0] w;
        w = '0;
        w[HDR_X_MSB:HDR_X_LSB] = ev.x;
        w[HDR_Y_MSB:HDR_Y_LSB] = ev.y;
        w[HDR_POL_BIT]         = ev.pol;
        w[HDR_VALID_BIT]       = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/prepare_output_data_if.sv
// Event stream input plus the BRAM-controller-style PS access port.
// master = PL event source and PS side, slave = prepare_output_data.
interface prepare_output_data_if;
    logic        in_valid;
    logic [31:0] in_timestamp;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        in_polarity;

    logic [11:0] axi_addr_in;
    logic        axi_en;
    logic        axi_we;
    logic [31:0] axi_data_in;
    logic [31:0] axi_data_out;

    logic        irq;
    logic        not_empty;

    modport master (
        output in_valid, in_timestamp, in_x, in_y, in_polarity,
        output axi_addr_in, axi_en, axi_we, axi_data_in,
        input  axi_data_out, irq, not_empty
    );

    modport slave (
        input  in_valid, in_timestamp, in_x, in_y, in_polarity,
        input  axi_addr_in, axi_en, axi_we, axi_data_in,
        output axi_data_out, irq, not_empty
    );
endinterface

// File: rtl/prepare_output_data_event_fifo.sv
// Single-clock FIFO of events with combinational head and flush.
// Caller qualifies push/pop; flush overrides both.
module prepare_output_data_event_fifo
    import prepare_output_data_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  event_t      i_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count,
    output logic [AW:0] o_count_next,
    output event_t      o_head
);

    event_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (i_push && !i_pop) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!i_push && i_pop) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
        end
    end

    // No reset on storage so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_full       = (r_count == (AW+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_head       = r_mem[r_rptr];

endmodule

// File: rtl/prepare_output_data.sv
// Buffers PL events in a FIFO and lets the PS drain them via a 32-bit register port,
// with status, a saturating drop counter and an occupancy threshold interrupt.
module prepare_output_data
    import prepare_output_data_pkg::*;
#(
    parameter int unsigned DEPTH         = 512,
    parameter int unsigned IRQ_THRESHOLD = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    prepare_output_data_if.slave  io_bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] IRQ_LEVEL = (AW+1)'(IRQ_THRESHOLD);

    logic        w_addr_ok;
    logic        w_rd;
    logic        w_wr;
    reg_sel_e    w_sel;
    logic        w_flush;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_underflow_set;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [AW:0] w_count_next;
    event_t      w_head;
    event_t      w_in_event;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    logic [15:0] r_drop_cnt;
    logic        r_underflow;
    logic [31:0] r_rdata;
    logic        r_irq;
    logic        r_not_empty;

    logic unused_bus;
    assign unused_bus = ^{io_bus.axi_data_in[31:1], io_bus.axi_addr_in[1:0]};

    assign w_addr_ok = (io_bus.axi_addr_in[11:4] == 8'h00);
    assign w_rd      = io_bus.axi_en && !io_bus.axi_we;
    assign w_wr      = io_bus.axi_en && io_bus.axi_we;
    assign w_sel     = reg_sel_e'(io_bus.axi_addr_in[3:2]);

    assign w_flush         = w_wr && w_addr_ok && (w_sel == RegStatus) && io_bus.axi_data_in[0];
    assign w_pop           = w_rd && w_addr_ok && (w_sel == RegTs) && !w_empty;
    assign w_underflow_set = w_rd && w_addr_ok && (w_sel == RegTs) && w_empty;
    // A same-edge pop frees a slot, so a push at full is still accepted.
    assign w_push = io_bus.in_valid && !w_flush && (!w_full || w_pop);
    assign w_drop = io_bus.in_valid && !w_flush && w_full && !w_pop;

    assign w_in_event = '{ts:  io_bus.in_timestamp,
                          x:   io_bus.in_x,
                          y:   io_bus.in_y,
                          pol: io_bus.in_polarity};

    prepare_output_data_event_fifo #(
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_data       (w_in_event),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_head       (w_head)
    );

    always_comb begin
        w_status                       = '0;
        w_status[STATUS_UNDERFLOW_BIT] = r_underflow;
        w_status[STATUS_EMPTY_BIT]     = w_empty;
        w_status[STATUS_FULL_BIT]      = w_full;
        w_status[15:0]                 = 16'(w_count);
    end

    always_comb begin
        w_rdata = '0;
        if (w_addr_ok) begin
            unique case (w_sel)
                RegStatus: w_rdata = w_status;
                RegHeader: w_rdata = w_empty ? 32'h0 : pack_header(w_head);
                RegTs:     w_rdata = w_empty ? 32'h0 : w_head.ts;
                RegDrops:  w_rdata = {16'h0, r_drop_cnt};
                default:   w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_drop_cnt  <= '0;
            r_underflow <= 1'b0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rdata;
            if (w_flush) begin
                r_drop_cnt  <= '0;
                r_underflow <= 1'b0;
            end else begin
                if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
                if (w_underflow_set) r_underflow <= 1'b1;
            end
            r_irq       <= (w_count_next >= IRQ_LEVEL);
            r_not_empty <= (w_count_next != '0);
        end
    end

    assign io_bus.axi_data_out = r_rdata;
    assign io_bus.irq          = r_irq;
    assign io_bus.not_empty    = r_not_empty;

endmodule

// File: tb/tb_prepare_output_data.sv
// Directed plus randomized checks of prepare_output_data against a queue-based model.
module tb_prepare_output_data;
    import prepare_output_data_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned THR   = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    prepare_output_data_if bus ();

    prepare_output_data #(
        .DEPTH         (DEPTH),
        .IRQ_THRESHOLD (THR)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0] ts;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        pol;
    } ev_s;

    ev_s         q[$];
    int unsigned m_drops;
    bit          m_uf;
    logic [31:0] m_rd;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(q.size());
        if (m_uf) s = s + 32'h8000_0000;
        if (q.size() == 0) s = s + 32'h4000_0000;
        if (q.size() == DEPTH) s = s + 32'h2000_0000;
        return s;
    endfunction

    function automatic logic [31:0] model_header(input ev_s e);
        return 32'(e.x) * 1024 + 32'(e.y) * 4 + 32'(e.pol) * 2 + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs to the model, clock the DUT, then compare outputs.
    task automatic step();
        bit          ok;
        logic [1:0]  sel;
        bit          rd;
        bit          flush;
        ev_s         e;
        if (!resetn) begin
            q.delete();
            m_drops = 0;
            m_uf    = 0;
            m_rd    = 0;
        end else begin
            ok    = (bus.axi_addr_in[11:4] == 8'h00);
            sel   = bus.axi_addr_in[3:2];
            rd    = bus.axi_en && !bus.axi_we;
            flush = bus.axi_en && bus.axi_we && ok && sel == 2'd0 && bus.axi_data_in[0];
            if (rd) begin
                m_rd = 0;
                if (ok) begin
                    case (sel)
                        2'd0: m_rd = model_status();
                        2'd1: if (q.size() > 0) m_rd = model_header(q[0]);
                        2'd2: if (q.size() > 0) m_rd = q[0].ts;
                        default: m_rd = m_drops;
                    endcase
                end
            end
            if (flush) begin
                q.delete();
                m_drops = 0;
                m_uf    = 0;
            end else begin
                if (rd && ok && sel == 2'd2) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else m_uf = 1;
                end
                if (bus.in_valid) begin
                    e.ts = bus.in_timestamp; e.x = bus.in_x; e.y = bus.in_y; e.pol = bus.in_polarity;
                    if (q.size() < DEPTH) q.push_back(e);
                    else if (m_drops < 65535) m_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rdata", bus.axi_data_out, m_rd);
        chk("irq", 32'(bus.irq), 32'(q.size() >= THR));
        chk("not_empty", 32'(bus.not_empty), 32'(q.size() != 0));
    endtask

    task automatic set_idle();
        bus.in_valid = 0; bus.in_timestamp = 0; bus.in_x = 0; bus.in_y = 0; bus.in_polarity = 0;
        bus.axi_en = 0; bus.axi_we = 0; bus.axi_addr_in = 0; bus.axi_data_in = 0;
    endtask

    task automatic rand_event();
        bus.in_valid = 1;
        bus.in_timestamp = $urandom;
        bus.in_x = 8'($urandom);
        bus.in_y = 8'($urandom);
        bus.in_polarity = 1'($urandom);
    endtask

    task automatic push(input logic [31:0] ts, input logic [7:0] x, input logic [7:0] y,
                        input logic p);
        bus.in_valid = 1; bus.in_timestamp = ts; bus.in_x = x; bus.in_y = y; bus.in_polarity = p;
        step();
        bus.in_valid = 0;
    endtask

    task automatic push_rand();
        rand_event();
        step();
        bus.in_valid = 0;
    endtask

    task automatic rd(input logic [11:0] addr);
        bus.axi_en = 1; bus.axi_we = 0; bus.axi_addr_in = addr;
        step();
        bus.axi_en = 0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        bus.axi_en = 1; bus.axi_we = 1; bus.axi_addr_in = addr; bus.axi_data_in = data;
        step();
        bus.axi_en = 0; bus.axi_we = 0;
    endtask

    initial begin
        int unsigned r;
        set_idle();

        resetn = 0;
        step();
        step();
        resetn = 1;
        rd(ADDR_STATUS);
        chk("reset_status", bus.axi_data_out, 32'h4000_0000);
        rd(ADDR_HEADER);
        chk("reset_header", bus.axi_data_out, 32'h0);
        chk("reset_irq", 32'(bus.irq), 32'h0);

        push(32'h1234_5678, 8'd5, 8'd9, 1'b1);
        rd(ADDR_HEADER);
        chk("header_word", bus.axi_data_out, 32'h0000_1427);
        rd(ADDR_TS);
        chk("ts_word", bus.axi_data_out, 32'h1234_5678);
        rd(ADDR_STATUS);
        chk("status_after_pop", bus.axi_data_out, 32'h4000_0000);

        for (int i = 0; i < 64; i++) push_rand();
        chk("irq_at_64", 32'(bus.irq), 32'h1);
        rd(ADDR_TS);
        chk("irq_at_63", 32'(bus.irq), 32'h0);
        rd(ADDR_STATUS);
        chk("status_63", bus.axi_data_out, 32'h0000_003F);

        for (int i = 0; i < 452; i++) push_rand();
        rd(ADDR_STATUS);
        chk("status_full", bus.axi_data_out, 32'h2000_0200);
        rd(ADDR_DROPS);
        chk("drops_3", bus.axi_data_out, 32'h3);
        rand_event();
        rd(ADDR_TS);
        bus.in_valid = 0;
        rd(ADDR_STATUS);
        chk("status_full_pushpop", bus.axi_data_out, 32'h2000_0200);
        rd(ADDR_DROPS);
        chk("drops_still_3", bus.axi_data_out, 32'h3);
        wr(ADDR_STATUS, 32'hFFFF_FFFE);
        rd(ADDR_STATUS);
        chk("ctrl_zero_noop", bus.axi_data_out, 32'h2000_0200);

        rand_event();
        wr(ADDR_STATUS, 32'h1);
        bus.in_valid = 0;
        rd(ADDR_STATUS);
        chk("flush_beats_push", bus.axi_data_out, 32'h4000_0000);
        rd(ADDR_DROPS);
        chk("flush_drops", bus.axi_data_out, 32'h0);

        rd(ADDR_TS);
        chk("ts_empty", bus.axi_data_out, 32'h0);
        wr(12'h010, 32'h1);
        rd(12'h010);
        chk("out_of_range_rd", bus.axi_data_out, 32'h0);
        rd(ADDR_STATUS);
        chk("status_underflow", bus.axi_data_out, 32'hC000_0000);
        wr(ADDR_STATUS, 32'h1);
        rd(ADDR_STATUS);
        chk("status_cleared", bus.axi_data_out, 32'h4000_0000);

        for (int i = 0; i < 5; i++) push_rand();
        rd(ADDR_HEADER);
        rand_event();
        resetn = 0;
        step();
        resetn = 1;
        bus.in_valid = 0;
        chk("midreset_rdata", bus.axi_data_out, 32'h0);
        chk("midreset_irq", 32'(bus.irq), 32'h0);
        rd(ADDR_STATUS);
        chk("midreset_status", bus.axi_data_out, 32'h4000_0000);

        // Random traffic: push-heavy first to reach full, then drain-heavy.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 900; i++) begin
                set_idle();
                r = $urandom_range(99, 0);
                if ($urandom_range(99, 0) < (phase == 0 ? 85 : 30)) rand_event();
                if (r < (phase == 0 ? 25 : 70)) begin
                    bus.axi_en = 1;
                    bus.axi_addr_in = {8'h00, 2'($urandom), 2'($urandom)};
                    if (r < (phase == 0 ? 15 : 50)) bus.axi_addr_in[3:2] = 2'd2;
                    if ($urandom_range(19, 0) == 0) bus.axi_addr_in[11:4] = 8'($urandom_range(255, 1));
                end else if (r > 98) begin
                    bus.axi_en = 1; bus.axi_we = 1;
                    bus.axi_addr_in = {8'h00, 2'($urandom), 2'b00};
                    bus.axi_data_in = $urandom;
                end
                step();
            end
        end
        set_idle();
        rd(ADDR_STATUS);
        rd(ADDR_DROPS);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prepare_output_data.md
Name: prepare_output_data

Overview:
Carries data from the PL event/result stream back to the PS. Each accepted event is stored in an on-chip FIFO. The PS drains the FIFO through the same 32-bit BRAM-controller-style port (en/we/addr) that the PS uses to inject events. Word layout is the inverse of the input path: header word = {14'b0, x, y, polarity, valid}, then a separate timestamp word. Also provides status, a drop counter, and a threshold interrupt.

Parameters:
DEPTH, 512, FIFO depth in events; must be a power of 2.
IRQ_THRESHOLD, 64, irq asserts when occupancy >= this value; range 1..DEPTH.

Ports:
clk  in  1  single clock for the PL and the PS port
resetn  in  1  synchronous active-low reset, sampled on posedge clk
in_valid  in  1  one event offered this cycle; there is no backpressure
in_timestamp  in  32  event timestamp
in_x  in  8  event x
in_y  in  8  event y
in_polarity  in  1  event polarity
axi_addr_in  in  12  byte address from the BRAM controller
axi_en  in  1  access strobe
axi_we  in  1  1 = write, 0 = read (single-bit strobe)
axi_data_in  in  32  write data
axi_data_out  out  32  read data, valid 1 cycle after the read strobe
irq  out  1  level interrupt: occupancy >= IRQ_THRESHOLD
not_empty  out  1  FIFO occupancy > 0

Behaviour:
- Reset (resetn=0 at posedge):
  - occupancy=0, read/write pointers=0.
  - drop_cnt=0, underflow=0.
  - axi_data_out=0, irq=0, not_empty=0.
- Address decode uses axi_addr_in[3:2]. If axi_addr_in[11:4]!=0, a read returns 0 and a write is ignored.
- 0x000 STATUS (read): [31] underflow sticky, [30] empty, [29] full, [15:0] occupancy, all other bits 0.
- 0x000 CTRL (write): data[0]=1 flushes the FIFO and clears drop_cnt and underflow. data[0]=0 has no effect.
- 0x004 HEADER (read, no pop):
  - FIFO not empty: head entry as {14'b0, x[17:10], y[9:2], pol[1], 1'b1}.
  - FIFO empty: returns 0.
- 0x008 TIMESTAMP (read):
  - FIFO not empty: returns the head timestamp and pops the entry.
  - FIFO empty: returns 0, sets underflow, no pop.
- 0x00C DROPS (read): {16'b0, drop_cnt}. drop_cnt saturates at 0xFFFF.
- Writes to 0x004/0x008/0x00C are ignored.
- Read latency: exactly 1 cycle.
  - Request on cycle N (axi_en=1, axi_we=0); axi_data_out is registered at posedge N+1 and held until the next read.
  - The read samples state as of cycle N, before any push or pop on the same edge.
- Push: in_valid=1 and not full -> write the entry; occupancy increments next cycle.
- Drop: in_valid=1 and full -> event lost, drop_cnt++ (saturating).
- Push and pop on the same edge: both take effect and occupancy is unchanged.
  - At full, the pop frees a slot, so the push is accepted, not dropped.
- Flush with a simultaneous push: flush wins. The push is discarded and not counted as a drop. A simultaneous pop is irrelevant.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- irq and not_empty are registered from the next-state occupancy, so they track occupancy with 0 added lag.
- Reset mid-operation: all state discarded; the next access sees an empty FIFO and zeroed counters.

Decomposition:
- Shared package:
  - Address constants ADDR_STATUS=0x000, ADDR_HEADER=0x004, ADDR_TS=0x008, ADDR_DROPS=0x00C.
  - Status bit indices 31/30/29.
  - Header field positions 17:10 / 9:2 / 1 / 0, which are also used by the input path.
- One sub-module: event_fifo.
  - Synchronous single-clock FIFO, 49-bit entries {ts, x, y, pol}.
  - Exposes push, pop, flush, full, empty, count, head.
  - head is valid combinationally; memory is inferred as distributed or BRAM.

Test Plan:
- Reset, then read 0x000 -> 0x40000000 (empty). Read 0x004 -> 0. irq=0, not_empty=0.
- Push (ts=0x12345678, x=5, y=9, pol=1). Read 0x004 -> 0x00001427. Read 0x008 -> 0x12345678. Then STATUS -> 0x40000000.
- Push 64 events -> irq=1 in the cycle after the 64th push. One TIMESTAMP read -> irq=0. STATUS[15:0]=63.
- Fill to DEPTH=512, push 3 more -> STATUS=0x20000200, DROPS=3. Push plus TIMESTAMP read in the same cycle at full -> occupancy stays 512, DROPS stays 3.
- TIMESTAMP read when empty -> returns 0, then STATUS=0xC0000000. Write 0x000 data=1 -> STATUS=0x40000000, DROPS=0.
- Push 5 events, assert resetn=0 for 1 cycle mid-stream -> STATUS=0x40000000, axi_data_out=0, irq=0.
